// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and the
// bit-period helper that uart_tx uses too, so both ends agree on timing.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned bit_count(input int unsigned clk_freq,
                                              input int unsigned bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input pin; the reset value
// is chosen per pin so an idle line does not look like an edge after reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-entry holding register (data/valid/require),
// framing-error pulse and sticky overrun flag.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       require,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int unsigned BIT_CNT  = bit_count(CLK_FREQ, UART_BPS);
    localparam int unsigned HALF_CNT = BIT_CNT / 2;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

    logic             rxd_s;
    logic             rxd_prev_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shreg_q;
    logic             deliver_q;
    logic             frame_err_q;

    logic [7:0]       data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (uart_rxd),
        .q_o (rxd_s)
    );

    // Receive FSM. Samples are taken only at bit centres; cnt restarts at each sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxd_prev_q  <= rxd_s;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (rxd_prev_q && !rxd_s) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shreg_q <= {rxd_s, shreg_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rxd_s) begin
                            deliver_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low break must not look like a new start bit.
                    if (rxd_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Holding register: a consume and a delivery in the same cycle swap the byte in place.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (require && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (deliver_q) begin
            if (valid_q && !require) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule
